dip_scan_ctrl: RTL and testbench
================================

# dip_scan_ctrl

Sequencing controller for the board's serial DIP-switch shift register. It periodically, or on request, drives the parallel-load strobe and a divided shift clock, and captures 16 serial bits. It applies the board's byte-swap ordering and, optionally, debounces across scans. It presents the switch word to the CPU datapath through a valid/acknowledge handshake with overrun detection.

## Interface
- CLK_DIV, 4: clk cycles per shift-clock half-period; legal range 1–255.
- SCAN_PERIOD, 1024: idle clk cycles between automatic scans; legal range 2–65535.
- STABLE_CNT, 3: identical consecutive scans required before DIP_data updates (debounce builds only); legal range 1–15.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- DIP_in  in  1  serial data from the switch shift register.
- scan_req  in  1  one-cycle request for an immediate scan.
- data_ack  in  1  CPU acknowledge; clears data_valid and overrun.
- DIP_latch  out  1  parallel-load strobe, active low.
- DIP_sclk  out  1  shift clock to the switch register.
- DIP_data  out  16  last accepted switch word.
- data_valid  out  1  new DIP_data not yet acknowledged.
- overrun  out  1  DIP_data replaced while data_valid was high; sticky.
- busy  out  1  scan in progress (state ≠ IDLE).

## Operation
- States: IDLE, LATCH, SHIFT, DONE.
- IDLE: the period counter increments each cycle.
  - Scan start: counter == SCAN_PERIOD-1, or scan_req == 1.
  - On scan start: counter clears and the FSM moves to LATCH.
  - scan_req is ignored outside IDLE and is not queued.
- LATCH: DIP_latch = 0 for 2*CLK_DIV cycles, then DIP_latch returns to 1 and the FSM moves to SHIFT.
- SHIFT: 16 bit slots, each 2*CLK_DIV cycles.
  - First half of each slot: DIP_sclk = 0. DIP_in is sampled on the last cycle of this half.
  - Second half of each slot: DIP_sclk = 1.
  - Bit counter 0–15. Sample k is written to raw[k].
  - After slot 15 the FSM moves to DONE.
- Ordering: word = {raw[7:0], raw[15:8]}.
  - The first serial bit lands in DIP_data[8].
  - The last serial bit lands in DIP_data[7].
- DONE (1 cycle): compare/update logic runs, then the FSM returns to IDLE.
  - Update condition: word is accepted (see Configuration) and differs from DIP_data.
  - On update: DIP_data ← word and data_valid ← 1.
  - If data_valid was already 1 at the update, overrun ← 1 as well.
- data_ack when data_valid == 1: data_valid ← 0 and overrun ← 0 on the next edge.
  - If an update and data_ack coincide, the update wins: data_valid stays 1 and overrun is unchanged.
  - data_ack while data_valid == 0 is ignored.

## Timing
- Reset values:
  - Outputs: DIP_latch = 1, DIP_sclk = 0, DIP_data = 0, data_valid = 0, overrun = 0, busy = 0.
  - Internal: state IDLE, counters 0, debounce candidate 0, stable count 0.
- Reset mid-scan aborts the scan and discards partial data. DIP_latch and DIP_sclk return to their reset values on the reset edge.
- Scan length: 34*CLK_DIV + 1 cycles from LATCH entry to IDLE re-entry (137 cycles at defaults).
- DIP_latch falls on the first clock edge after the start condition is seen.
- data_valid and the new DIP_data appear together, on the edge that leaves DONE.
- Automatic scan spacing: SCAN_PERIOD idle cycles plus the scan length.
- The first automatic scan after reset starts SCAN_PERIOD cycles after rst deasserts.

## Configuration
- Macro DIP_DEBOUNCE_EN defined:
  - Word equal to the candidate: stable count increments, saturating at 15.
  - Word not equal to the candidate: candidate ← word, stable count ← 1.
  - The word is accepted when the stable count ≥ STABLE_CNT after this update.
- Macro undefined: every completed scan's word is accepted. The candidate and stable-count registers are not built, and STABLE_CNT is unused.

## Test plan
- Default params, reset, serial stream 0xA5 then 0x3C (first bit first, LSB-first per byte) → DIP_data = 0x3CA5 is not expected; required result is raw = 0x3CA5 → DIP_data = 0xA53C, with data_valid = 1 at cycle 137 after LATCH entry.
- scan_req pulse in IDLE → DIP_latch low for exactly 8 cycles, then 16 DIP_sclk pulses, each 4 high / 4 low.
- DIP_DEBOUNCE_EN, STABLE_CNT = 3, scans of 0x1234, 0x1234, 0x9999, 0x1234, 0x1234, 0x1234 → DIP_data changes only after the sixth scan.
- Two differing updates with no data_ack → overrun = 1 and DIP_data = second word. Then data_ack → data_valid = 0 and overrun = 0 on the next cycle.
- rst asserted during SHIFT bit 7 → all outputs at reset values on the next edge, and the next scan captures a full fresh word.
- Scan returning a value equal to DIP_data → no data_valid pulse, and DIP_data is unchanged.

Source files
------------

// File: rtl/dip_scan_ctrl_if.sv
// Signal bundle between the DIP scan controller, the switch shift register and the CPU datapath.
interface dip_scan_ctrl_if;
  logic        DIP_in;
  logic        scan_req;
  logic        data_ack;
  logic        DIP_latch;
  logic        DIP_sclk;
  logic [15:0] DIP_data;
  logic        data_valid;
  logic        overrun;
  logic        busy;

  modport master (
    output DIP_in, scan_req, data_ack,
    input  DIP_latch, DIP_sclk, DIP_data, data_valid, overrun, busy
  );

  modport slave (
    input  DIP_in, scan_req, data_ack,
    output DIP_latch, DIP_sclk, DIP_data, data_valid, overrun, busy
  );
endinterface

// File: rtl/dip_scan_ctrl.sv
// Serial DIP-switch scan sequencer with byte-swapped capture and valid/ack handshake.
// Optional cross-scan debounce is built when DIP_DEBOUNCE_EN is defined.
module dip_scan_ctrl #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SCAN_PERIOD = 1024,
  parameter int unsigned STABLE_CNT  = 3
) (
  input logic            clk,
  input logic            rst,
  dip_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_e;

  localparam logic [8:0]  SLOT_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0]  HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [15:0] PER_LAST  = 16'(SCAN_PERIOD - 1);

  state_e      state_q, state_d;
  logic [8:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] per_q, per_d;
  logic [15:0] raw_q, raw_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic [15:0] word;
  logic        accept;

  assign word = {raw_q[7:0], raw_q[15:8]};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    per_d   = per_q;
    raw_d   = raw_q;
    case (state_q)
      IDLE: begin
        if (per_q == PER_LAST || bus.scan_req) begin
          per_d   = '0;
          div_d   = '0;
          bit_d   = '0;
          state_d = LATCH;
        end else begin
          per_d = per_q + 16'd1;
        end
      end
      LATCH: begin
        if (div_q == SLOT_LAST) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      SHIFT: begin
        // Sample on the final low cycle, just before the register sees the rising shift clock.
        if (div_q == HALF_LAST) raw_d[bit_q] = bus.DIP_in;
        if (div_q == SLOT_LAST) begin
          div_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = DONE;
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DIP_DEBOUNCE_EN
  logic [15:0] cand_q, cand_d;
  logic [3:0]  stab_q, stab_d;

  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    accept = 1'b0;
    if (state_q == DONE) begin
      if (word == cand_q) begin
        if (stab_q != 4'hF) stab_d = stab_q + 4'd1;
      end else begin
        cand_d = word;
        stab_d = 4'd1;
      end
      accept = (32'(stab_d) >= STABLE_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      stab_q <= '0;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
    end
  end
`else
  logic [31:0] unused_stable_cnt;
  assign unused_stable_cnt = 32'(STABLE_CNT);
  assign accept = (state_q == DONE);
`endif

  // A fresh update takes priority over a coincident acknowledge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (accept && word != data_q) begin
      data_d  = word;
      valid_d = 1'b1;
      ovr_d   = ovr_q | valid_q;
    end else if (bus.data_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      per_q   <= '0;
      raw_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      per_q   <= per_d;
      raw_q   <= raw_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.DIP_latch  = (state_q != LATCH);
  assign bus.DIP_sclk   = (state_q == SHIFT) && (div_q > HALF_LAST);
  assign bus.DIP_data   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dip_scan_ctrl.sv
// Scoreboard bench for dip_scan_ctrl: directed serial words, monitor checks every DIP_data update.
module tb_dip_scan_ctrl;
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned SCAN_PERIOD = 200;
  localparam int unsigned STABLE_CNT  = 3;
`ifdef DIP_DEBOUNCE_EN
  localparam int unsigned NREP = STABLE_CNT;
`else
  localparam int unsigned NREP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dip_scan_ctrl_if bus ();

  dip_scan_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .SCAN_PERIOD(SCAN_PERIOD),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        ovr;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Switch shift register model: parallel load while latch low, advance on each sclk rise.
  logic [15:0] ser_word  = '0;
  int          idx       = 0;
  logic        sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (!bus.DIP_latch) idx = 0;
    else if (bus.DIP_sclk && !sclk_prev) idx++;
    sclk_prev  = bus.DIP_sclk;
    bus.DIP_in = (idx < 16) ? ser_word[idx] : 1'b0;
  end

  // Monitor: any new word or valid rise must match the head of the scoreboard.
  logic [15:0] prev_data  = '0;
  logic        prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_data  = '0;
      prev_valid = 1'b0;
    end else begin
      if (bus.DIP_data !== prev_data || (bus.data_valid && !prev_valid)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_update: actual 0x%0h, required no update", bus.DIP_data);
        end else begin
          e = sb.pop_front();
          check("sb_data", bus.DIP_data, e.data);
          check("sb_valid", bus.data_valid, 1);
          check("sb_overrun", bus.overrun, e.ovr);
        end
      end
      prev_data  = bus.DIP_data;
      prev_valid = bus.data_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_latch"},   bus.DIP_latch, 1);
    check({tag, "_sclk"},    bus.DIP_sclk, 0);
    check({tag, "_data"},    bus.DIP_data, 0);
    check({tag, "_valid"},   bus.data_valid, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
    check({tag, "_busy"},    bus.busy, 0);
  endtask

  task automatic do_scan(input logic [15:0] raw);
    int n;
    ser_word     = raw;
    bus.scan_req = 1'b1;
    tick();
    bus.scan_req = 1'b0;
    check("scan_start_busy", bus.busy, 1);
    n = 0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    check("scan_end_busy", bus.busy, 0);
    tick();
  endtask

  task automatic do_scan_acc(input logic [15:0] raw, input logic [15:0] exp_word, input logic ovr);
    exp_t e;
    for (int unsigned r = 0; r < NREP; r++) begin
      if (r == NREP - 1) begin
        e.data = exp_word;
        e.ovr  = ovr;
        sb.push_back(e);
      end
      do_scan(raw);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          lat_low, rises, bad_hi, bad_lo, hi_run, lo_run, first_hi, valid_at;
    logic        sp;
    exp_t        e;
    logic [15:0] deb_raw [5];
    logic [15:0] eq_raw, eq_word;

    bus.scan_req = 1'b0;
    bus.data_ack = 1'b0;
    rst          = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");

    // First automatic scan: serial 0xA5 then 0x3C -> raw 0x3CA5 -> word 0xA53C.
    ser_word = 16'h3CA5;
`ifndef DIP_DEBOUNCE_EN
    e.data = 16'hA53C;
    e.ovr  = 1'b0;
    sb.push_back(e);
`endif
    rst = 1'b0;
    n   = 0;
    while (bus.DIP_latch && n < 1000) begin
      tick();
      n++;
    end
    check("auto_start_delay", n, SCAN_PERIOD);

    lat_low = 0; rises = 0; bad_hi = 0; bad_lo = 0;
    hi_run = 0; lo_run = 0; first_hi = -1; valid_at = -1; sp = 1'b0;
    for (int i = 0; i < 140; i++) begin
      if (!bus.DIP_latch) lat_low++;
      if (bus.DIP_sclk) begin
        if (!sp) begin
          rises++;
          if (first_hi < 0) first_hi = i;
          if (rises > 1 && lo_run != 4) bad_lo++;
        end
        hi_run++;
      end else begin
        if (sp) begin
          if (hi_run != 4) bad_hi++;
          hi_run = 0;
          lo_run = 0;
        end
        lo_run++;
      end
      sp = bus.DIP_sclk;
      if (bus.data_valid && valid_at < 0) valid_at = i;
      if (i != 139) tick();
    end
    check("latch_low_cycles", lat_low, 8);
    check("sclk_pulses", rises, 16);
    check("sclk_high_width_errs", bad_hi, 0);
    check("sclk_low_width_errs", bad_lo, 0);
    check("first_sclk_high", first_hi, 12);
`ifdef DIP_DEBOUNCE_EN
    check("valid_latency", valid_at, -1);
`else
    check("valid_latency", valid_at, 137);
`endif
    check("idle_after_scan", bus.busy, 0);

    pulse_ack();
    check("ack_valid", bus.data_valid, 0);
    check("ack_overrun", bus.overrun, 0);

`ifdef DIP_DEBOUNCE_EN
    deb_raw = '{16'h1234, 16'h1234, 16'h9999, 16'h1234, 16'h1234};
    foreach (deb_raw[k]) begin
      do_scan(deb_raw[k]);
      check("debounce_hold", bus.DIP_data, 16'h0000);
    end
    e.data = 16'h3412;
    e.ovr  = 1'b0;
    sb.push_back(e);
    do_scan(16'h1234);
    check("debounce_accept", bus.DIP_data, 16'h3412);
    pulse_ack();
    eq_raw  = 16'h1234;
    eq_word = 16'h3412;
`else
    deb_raw = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    eq_raw  = 16'h3CA5;
    eq_word = 16'hA53C;
`endif

    // Scan returning the word already held: no update.
    do_scan(eq_raw);
    check("equal_valid", bus.data_valid, 0);
    check("equal_data", bus.DIP_data, eq_word);

    // Two differing updates without acknowledge.
    do_scan_acc(16'h00FF, 16'hFF00, 1'b0);
    do_scan_acc(16'h5AC3, 16'hC35A, 1'b1);
    check("overrun_set", bus.overrun, 1);
    check("overrun_data", bus.DIP_data, 16'hC35A);
    check("overrun_valid", bus.data_valid, 1);
    pulse_ack();
    check("ack2_valid", bus.data_valid, 0);
    check("ack2_overrun", bus.overrun, 0);

    // Reset during SHIFT bit 7 aborts the scan.
    ser_word     = 16'hFFFF;
    bus.scan_req = 1'b1;
    tick();
    bus.scan_req = 1'b0;
    repeat (66) tick();
    check("midscan_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    check_reset_vals("midscan_reset");
    tick();
    rst = 1'b0;

    do_scan_acc(16'h8001, 16'h0180, 1'b0);
    check("fresh_data", bus.DIP_data, 16'h0180);

    tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
